// File: rtl/snes_pad_poller_pkg.sv
// Shared types and constants for the SNES pad poller: FSM states, button bit
// indices and the frame layout of the serial pad word.
package snes_pad_poller_pkg;

  localparam int unsigned FRAME_BITS   = 17;
  localparam int unsigned PRESENCE_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_WAIT0,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_DONE
  } state_e;

  typedef enum int unsigned {
    BTN_B     = 0,
    BTN_Y     = 1,
    BTN_SEL   = 2,
    BTN_START = 3,
    BTN_UP    = 4,
    BTN_DOWN  = 5,
    BTN_LEFT  = 6,
    BTN_RIGHT = 7,
    BTN_A     = 8,
    BTN_X     = 9,
    BTN_L     = 10,
    BTN_R     = 11
  } btn_idx_e;

  // Wire word is active-low; an absent pad reports no buttons at all.
  function automatic logic [15:0] decode_buttons(input logic [FRAME_BITS-1:0] shift);
    decode_buttons = shift[PRESENCE_BIT] ? '0 : ~shift[15:0];
  endfunction

endpackage

// File: rtl/snes_pad_poller_pad_sync_shift.sv
// Per-pad input path: 2-flop synchronizer on the serial data line feeding a
// 17-bit shift register; the first sample taken ends up in bit 0.
module pad_sync_shift
  import snes_pad_poller_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  data_i,
  input  logic                  sample_i,
  output logic [FRAME_BITS-1:0] shift_o
);

  logic                  meta_q;
  logic                  sync_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] shift_d;

  always_comb begin
    shift_d = shift_q;
    if (sample_i) begin
      shift_d = {sync_q, shift_q[FRAME_BITS-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      shift_q <= '1;
    end else begin
      meta_q  <= data_i;
      sync_q  <= meta_q;
      shift_q <= shift_d;
    end
  end

  assign shift_o = shift_q;

endmodule

// File: rtl/snes_pad_poller.sv
// Polls two SNES-style pads over shared latch/clock lines and publishes
// frame-consistent, active-high button words with presence flags.
module snes_pad_poller
  import snes_pad_poller_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = 300,
  parameter int unsigned POLL_CYCLES = 833333
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        poll_req,
  input  logic [1:0]  pad_data,
  output logic        pad_latch,
  output logic        pad_clk,
  output logic        poll_busy,
  output logic [15:0] p1_buttons,
  output logic [15:0] p2_buttons,
  output logic        p1_present,
  output logic        p2_present,
  output logic        buttons_valid
);

  localparam int unsigned CNT_W = $clog2(2 * HALF_CYCLES);
  localparam int unsigned TMR_W = $clog2(POLL_CYCLES);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * HALF_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_CYCLES - 1);
  localparam logic [4:0]       LAST_BIT   = 5'(FRAME_BITS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       bit_q, bit_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             pending_q, pending_d;
  logic [15:0]      p1_q, p1_d, p2_q, p2_d;
  logic             pres1_q, pres1_d, pres2_q, pres2_d;
  logic             valid_q, valid_d;

  logic                  timer_wrap;
  logic                  start;
  logic                  cnt_last;
  logic                  sample_en;
  logic [FRAME_BITS-1:0] shift1, shift2;

  pad_sync_shift u_pad1 (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .data_i   (pad_data[0]),
    .sample_i (sample_en),
    .shift_o  (shift1)
  );

  pad_sync_shift u_pad2 (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .data_i   (pad_data[1]),
    .sample_i (sample_en),
    .shift_o  (shift2)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      timer_q   <= '0;
      pending_q <= 1'b0;
      p1_q      <= '0;
      p2_q      <= '0;
      pres1_q   <= 1'b0;
      pres2_q   <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      timer_q   <= timer_d;
      pending_q <= pending_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      pres1_q   <= pres1_d;
      pres2_q   <= pres2_d;
      valid_q   <= valid_d;
    end
  end

  assign timer_wrap = enable && (timer_q == TMR_LAST);
  assign start      = timer_wrap || poll_req;
  assign cnt_last   = (state_q == ST_LATCH) ? (cnt_q == LATCH_LAST) : (cnt_q == HALF_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_d     = bit_q;
    timer_d   = '0;
    pending_d = pending_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    pres1_d   = pres1_q;
    pres2_d   = pres2_q;
    valid_d   = (state_q == ST_DONE);

    if (enable && !timer_wrap) begin
      timer_d = timer_q + 1'b1;
    end

    // A start outside IDLE is remembered once; IDLE launches and clears it.
    if (state_q == ST_IDLE) begin
      pending_d = 1'b0;
    end else if (start) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start || pending_q) begin
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (cnt_last) begin
          state_d = ST_WAIT0;
          cnt_d   = '0;
        end
      end
      ST_WAIT0: begin
        if (cnt_last) begin
          state_d = ST_CLK_LO;
          cnt_d   = '0;
          bit_d   = 5'd1;
        end
      end
      ST_CLK_LO: begin
        if (cnt_last) begin
          state_d = ST_CLK_HI;
          cnt_d   = '0;
        end
      end
      ST_CLK_HI: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_CLK_LO;
            bit_d   = bit_q + 5'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        p1_d    = decode_buttons(shift1);
        p2_d    = decode_buttons(shift2);
        pres1_d = ~shift1[PRESENCE_BIT];
        pres2_d = ~shift2[PRESENCE_BIT];
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pad_latch = (state_q == ST_LATCH);
    pad_clk   = (state_q != ST_CLK_LO);
    poll_busy = (state_q != ST_IDLE);
    sample_en = ((state_q == ST_WAIT0) || (state_q == ST_CLK_HI)) && (cnt_q == HALF_LAST);
  end

  assign p1_buttons    = p1_q;
  assign p2_buttons    = p2_q;
  assign p1_present    = pres1_q;
  assign p2_present    = pres2_q;
  assign buttons_valid = valid_q;

endmodule
